fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/npc_sel.sv | 28 ++
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_stage_pkg;

  localparam int unsigned Xlen = 32;

  // Opcode occupies the top six instruction bits.
  localparam logic [5:0]      OpHalt  = 6'b111111;
  localparam logic [Xlen-1:0] InstNop = 32'h0000_0000;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StHaltPend = 2'd1,
    StHalted   = 2'd2
  } fetch_state_e;

  function automatic logic is_halt(input logic [Xlen-1:0] inst);
    return inst[31:26] == OpHalt;
  endfunction

endpackage

// File: rtl/npc_sel.sv
// Next-PC selection: hold > jump > taken branch > sequential.
module npc_sel
  import fetch_stage_pkg::*;
(
  input  logic [Xlen-1:0] pc_i,
  input  logic            hold_i,
  input  logic            jump_i,
  input  logic            branch_taken_i,
  input  logic [Xlen-1:0] jump_target_i,
  input  logic [Xlen-1:0] branch_target_i,
  output logic [Xlen-1:0] pc4_o,
  output logic [Xlen-1:0] npc_o
);

  always_comb begin
    pc4_o = pc_i + 32'd4;
    if (hold_i) begin
      npc_o = pc_i;
    end else if (jump_i) begin
      npc_o = jump_target_i;
    end else if (branch_taken_i) begin
      npc_o = branch_target_i;
    end else begin
      npc_o = pc4_o;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and HALT handling.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            nWrite_PC,
  input  logic            nWrite_IF_ID,
  input  logic            flush_IF_ID,
  input  logic            jump_ID,
  input  logic            branch_taken_ID,
  input  logic [Xlen-1:0] jump_target_ID,
  input  logic [Xlen-1:0] branch_target_ID,
  output logic [Xlen-1:0] inst_addr,
  input  logic [Xlen-1:0] inst_data,
  output logic [Xlen-1:0] inst_IF_ID,
  output logic [Xlen-1:0] pc4_IF_ID,
  output logic            valid_IF_ID,
  output logic            halted,
  output logic [Xlen-1:0] fetch_count
);

  fetch_state_e    state_q, state_d;
  logic [Xlen-1:0] pc_q, pc_d;
  logic [Xlen-1:0] inst_q, inst_d;
  logic [Xlen-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic [Xlen-1:0] count_q, count_d;
  logic [Xlen-1:0] pc4;
  logic [Xlen-1:0] npc;
  logic            ifid_hold;

  npc_sel u_npc_sel (
    .pc_i            (pc_q),
    .hold_i          (nWrite_PC),
    .jump_i          (jump_ID),
    .branch_taken_i  (branch_taken_ID),
    .jump_target_i   (jump_target_ID),
    .branch_target_i (branch_target_ID),
    .pc4_o           (pc4),
    .npc_o           (npc)
  );

  // A stall coinciding with a flush freezes IF/ID too; the redirect re-resolves next cycle.
  assign ifid_hold = nWrite_IF_ID | (nWrite_PC & flush_IF_ID);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    count_d  = count_q;
    unique case (state_q)
      StRun: begin
        pc_d = npc;
        if (!ifid_hold) begin
          if (flush_IF_ID) begin
            inst_d  = InstNop;
            pc4_d   = '0;
            valid_d = 1'b0;
          end else begin
            inst_d  = inst_data;
            pc4_d   = pc4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
            if (is_halt(inst_data)) begin
              state_d = StHaltPend;
              pc_d    = pc_q;
            end
          end
        end
      end
      StHaltPend: begin
        if (!ifid_hold) begin
          inst_d  = InstNop;
          pc4_d   = '0;
          valid_d = 1'b0;
          // A flush here means the HALT was fetched down a mispredicted path.
          if (flush_IF_ID) begin
            state_d = StRun;
            pc_d    = npc;
          end else begin
            state_d  = StHalted;
            halted_d = 1'b1;
          end
        end
      end
      StHalted: begin
        inst_d   = InstNop;
        pc4_d    = '0;
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      pc_q     <= '0;
      inst_q   <= InstNop;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign inst_addr   = pc_q;
  assign inst_IF_ID  = inst_q;
  assign pc4_IF_ID   = pc4_q;
  assign valid_IF_ID = valid_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios plus randomized control traffic.
module tb_fetch_stage;

  localparam logic [31:0] HaltInst = 32'hFC00_0000;
  localparam logic [31:0] DefInst  = 32'h2008_0005;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nWrite_PC = 1'b0, nWrite_IF_ID = 1'b0, flush_IF_ID = 1'b0;
  logic        jump_ID = 1'b0, branch_taken_ID = 1'b0;
  logic [31:0] jump_target_ID = '0, branch_target_ID = '0;
  logic [31:0] inst_addr, inst_data, inst_IF_ID, pc4_IF_ID, fetch_count;
  logic        valid_IF_ID, halted;

  fetch_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .nWrite_PC        (nWrite_PC),
    .nWrite_IF_ID     (nWrite_IF_ID),
    .flush_IF_ID      (flush_IF_ID),
    .jump_ID          (jump_ID),
    .branch_taken_ID  (branch_taken_ID),
    .jump_target_ID   (jump_target_ID),
    .branch_target_ID (branch_target_ID),
    .inst_addr        (inst_addr),
    .inst_data        (inst_data),
    .inst_IF_ID       (inst_IF_ID),
    .pc4_IF_ID        (pc4_IF_ID),
    .valid_IF_ID      (valid_IF_ID),
    .halted           (halted),
    .fetch_count      (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic [31:0] cnt;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Instruction memory: sparse overrides over a default or hashed background.
  logic [31:0] mem_ovr[logic [31:0]];
  bit          rand_mem = 1'b0;
  logic [31:0] mem_seed = '0;
  int          mem_gen = 0;

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    logic [31:0] x;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    if (!rand_mem) return DefInst;
    x = (a ^ mem_seed) * 32'h9E37_79B1;
    x = x ^ (x >> 15);
    if (x[31:26] == 6'h3F) x[26] = 1'b0;
    if (x[7:2] == 6'd0) x[31:26] = 6'h3F;
    return x;
  endfunction

  always @(inst_addr or mem_gen) inst_data = inst_at(inst_addr);

  // Reference model: architectural view of the stage.
  logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
  logic        m_valid;
  int          m_mode;  // 0 running, 1 halt pending, 2 halted

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("inst_addr", inst_addr, e.addr);
        check("inst_IF_ID", inst_IF_ID, e.inst);
        check("pc4_IF_ID", pc4_IF_ID, e.pc4);
        check("fetch_count", fetch_count, e.cnt);
        check("valid_IF_ID", {31'd0, valid_IF_ID}, {31'd0, e.valid});
        check("halted", {31'd0, halted}, {31'd0, e.halted});
      end
    end
  end

  task automatic model_reset();
    m_pc = '0; m_inst = '0; m_pc4 = '0; m_cnt = '0; m_valid = 1'b0; m_mode = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {nWrite_PC, nWrite_IF_ID, flush_IF_ID, jump_ID, branch_taken_ID} = '0;
    model_reset();
    #1;
    check("rst_inst_addr", inst_addr, 32'h0);
    check("rst_inst_IF_ID", inst_IF_ID, 32'h0);
    check("rst_pc4_IF_ID", pc4_IF_ID, 32'h0);
    check("rst_fetch_count", fetch_count, 32'h0);
    check("rst_valid", {31'd0, valid_IF_ID}, 32'h0);
    check("rst_halted", {31'd0, halted}, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic bubble();
    m_inst = '0; m_pc4 = '0; m_valid = 1'b0;
  endtask

  task automatic step(input logic spc, input logic sifid, input logic fl, input logic jmp,
                      input logic br, input logic [31:0] jt, input logic [31:0] bt);
    logic [31:0] fetched, target, nxt;
    bit          freeze;
    exp_t        e;
    nWrite_PC = spc; nWrite_IF_ID = sifid; flush_IF_ID = fl;
    jump_ID = jmp; branch_taken_ID = br; jump_target_ID = jt; branch_target_ID = bt;
    fetched = inst_at(m_pc);
    freeze  = sifid || (spc && fl);
    target  = jmp ? jt : (br ? bt : m_pc + 32'd4);
    nxt     = m_pc;
    if (m_mode == 0) begin
      nxt = spc ? m_pc : target;
      if (!freeze) begin
        if (fl) begin
          bubble();
        end else begin
          m_inst = fetched; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
          if (fetched[31:26] == 6'h3F) begin
            nxt = m_pc;
            m_mode = 1;
          end
        end
      end
    end else if (m_mode == 1) begin
      if (!freeze) begin
        bubble();
        if (fl) begin
          m_mode = 0;
          nxt = target;
        end else begin
          m_mode = 2;
        end
      end
    end else begin
      bubble();
    end
    m_pc = nxt;
    e.addr = m_pc; e.inst = m_inst; e.pc4 = m_pc4; e.cnt = m_cnt;
    e.valid = m_valid; e.halted = (m_mode == 2);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic jump_flush(input logic [31:0] t);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, t, 32'h0);
  endtask

  initial begin
    logic        spc, sifid, fl, jmp, br;
    logic [31:0] jt, bt;
    int          waited;

    do_reset();
    // Straight-line fetch from address 0.
    idle();
    check("seq_addr_1", inst_addr, 32'h4);
    check("seq_pc4_1", pc4_IF_ID, 32'h4);
    idle();
    check("seq_addr_2", inst_addr, 32'h8);
    check("seq_pc4_2", pc4_IF_ID, 32'h8);
    idle();
    check("seq_pc4_3", pc4_IF_ID, 32'hC);
    check("seq_count_3", fetch_count, 32'd3);
    idle();
    // Full stall at 0x10.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("stall_addr", inst_addr, 32'h10);
    check("stall_pc4", pc4_IF_ID, 32'h10);
    check("stall_count", fetch_count, 32'd4);
    repeat (4) idle();
    check("pre_jump_addr", inst_addr, 32'h20);
    jump_flush(32'h100);
    check("jump_addr", inst_addr, 32'h100);
    check("jump_valid", {31'd0, valid_IF_ID}, 32'h0);
    check("jump_inst", inst_IF_ID, 32'h0);
    // Stall and flush together defer the branch by one cycle.
    jump_flush(32'h30);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h80);
    check("stall_flush_addr", inst_addr, 32'h30);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h80);
    check("branch_addr", inst_addr, 32'h80);
    // Sequential wrap at the top of the address space.
    jump_flush(32'hFFFF_FFFC);
    idle();
    check("wrap_addr", inst_addr, 32'h0);
    check("wrap_pc4", pc4_IF_ID, 32'h0);
    // HALT on the committed path.
    mem_ovr[32'h40] = HaltInst;
    mem_ovr[32'h44] = HaltInst;
    mem_gen++;
    jump_flush(32'h40);
    idle();
    check("halt_loaded_valid", {31'd0, valid_IF_ID}, 32'h1);
    check("halt_pend_addr", inst_addr, 32'h40);
    idle();
    check("halted_set", {31'd0, halted}, 32'h1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0);
    check("halted_addr", inst_addr, 32'h40);
    check("halted_valid", {31'd0, valid_IF_ID}, 32'h0);
    check("halted_hold", {31'd0, halted}, 32'h1);
    // Reset abandons HALTED; first fetch is address 0.
    do_reset();
    idle();
    check("post_halt_pc4", pc4_IF_ID, 32'h4);
    check("post_halt_halted", {31'd0, halted}, 32'h0);
    // HALT fetched on a mispredicted path.
    jump_flush(32'h44);
    idle();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h200);
    check("spec_halt_addr", inst_addr, 32'h200);
    check("spec_halt_halted", {31'd0, halted}, 32'h0);
    idle();
    check("spec_halt_valid", {31'd0, valid_IF_ID}, 32'h1);

    // Randomized traffic over a hashed memory image.
    mem_ovr.delete();
    rand_mem = 1'b1;
    for (int run = 0; run < 6; run++) begin
      mem_seed = $urandom;
      mem_gen++;
      do_reset();
      for (int c = 0; c < 150; c++) begin
        spc   = ($urandom_range(0, 99) < 20);
        sifid = spc ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 99) < 8);
        fl    = ($urandom_range(0, 99) < 20);
        jmp   = ($urandom_range(0, 99) < 10);
        br    = ($urandom_range(0, 99) < 15);
        jt    = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        bt    = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        if ($urandom_range(0, 199) == 0) do_reset();
        else step(spc, sifid, fl, jmp, br, jt, bt);
      end
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      #2;
      waited++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
